// File: rtl/cr_iu_hs_pkg.sv
// cr_iu_hs_pkg: shared types for the IU hardware-stacking split injector.
// State encoding and FIFO entry layout.
package cr_iu_hs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DRAIN  = 2'b10,
    CHGFLW = 2'b11
  } hs_state_t;

  // {op[31:0], retire_mask, gpr_clr, last}
  localparam int ENTRY_W = 35;

endpackage

// File: rtl/cr_iu_hs_inject_fifo.sv
// cr_iu_hs_inject_fifo: generic DEPTH-entry synchronous FIFO.
// Registered head output, flush empties, no read/write bypass.
module cr_iu_hs_inject_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 35,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wp] <= din;
  end

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rp];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/cr_iu_hs_split_inject.sv
// cr_iu_hs_split_inject: buffers split micro-ops toward EX, throttles the
// splitter and raises change-of-flow when the final unstack op retires.
module cr_iu_hs_split_inject
  import cr_iu_hs_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 4
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             hs_split_iu_ctrl_inst_vld,
  input  logic [31:0]      hs_split_iu_dp_inst_op,
  input  logic             hs_split_iu_hs_retire_mask,
  input  logic             hs_split_iu_nsinst_gpr_rst_b,
  input  logic             hs_split_iu_unstack_chgflw,
  input  logic             ex_inject_accept,
  input  logic             ex_inject_flush,
  output logic             iu_hs_split_ex_stall,
  output logic             iu_ifu_spcu_int_en,
  output logic             inject_ex_inst_vld,
  output logic [31:0]      inject_ex_inst_op,
  output logic             inject_ex_retire_mask,
  output logic             inject_ex_gpr_clr,
  output logic             inject_pcgen_chgflw,
  output logic [CNT_W-1:0] inject_seq_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] din;
  logic [ENTRY_W-1:0] dout;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  logic [CW-1:0]      cnt_nxt;
  hs_state_t          state;
  hs_state_t          state_nxt;
  logic [CNT_W-1:0]   seq_q;
  logic [CNT_W-1:0]   seq_nxt;
  logic               stall_q;
  logic               int_en_q;
  logic               chgflw_q;

  assign push = hs_split_iu_ctrl_inst_vld & ~stall_q
              & ~full & ~ex_inject_flush;
  assign pop  = ex_inject_accept & ~empty & ~ex_inject_flush;

  assign din = {hs_split_iu_dp_inst_op,
                hs_split_iu_hs_retire_mask,
                ~hs_split_iu_nsinst_gpr_rst_b,
                hs_split_iu_unstack_chgflw};

  cr_iu_hs_inject_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (forever_cpuclk),
    .rst   (cpurst),
    .push  (push),
    .pop   (pop),
    .flush (ex_inject_flush),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    cnt_nxt = count + CW'(push) - CW'(pop);
    if (ex_inject_flush) cnt_nxt = '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (push)
          state_nxt = hs_split_iu_unstack_chgflw ? DRAIN : ACTIVE;
      ACTIVE:
        if (push && hs_split_iu_unstack_chgflw)
          state_nxt = DRAIN;
        else if (empty && !hs_split_iu_ctrl_inst_vld)
          state_nxt = IDLE;
      DRAIN:
        if (pop && dout[0]) state_nxt = CHGFLW;
      CHGFLW:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
    if (ex_inject_flush) state_nxt = IDLE;
  end

  // only retiring ops count; IDLE always restarts the sequence count
  always_comb begin
    seq_nxt = seq_q;
    if (pop && !dout[2] && seq_q != '1)
      seq_nxt = seq_q + 1'b1;
    if (state_nxt == IDLE) seq_nxt = '0;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state    <= IDLE;
      stall_q  <= 1'b0;
      int_en_q <= 1'b1;
      chgflw_q <= 1'b0;
      seq_q    <= '0;
    end else begin
      state    <= state_nxt;
      stall_q  <= (cnt_nxt == CW'(DEPTH))
                | (state_nxt == DRAIN)
                | (state_nxt == CHGFLW);
      int_en_q <= (state_nxt == IDLE) && (cnt_nxt == '0);
      chgflw_q <= (state_nxt == CHGFLW);
      seq_q    <= seq_nxt;
    end
  end

  assign head = empty ? '0 : dout;

  assign iu_hs_split_ex_stall  = stall_q;
  assign iu_ifu_spcu_int_en    = int_en_q;
  assign inject_ex_inst_vld    = ~empty;
  assign inject_ex_inst_op     = head[34:3];
  assign inject_ex_retire_mask = head[2];
  assign inject_ex_gpr_clr     = head[1];
  assign inject_pcgen_chgflw   = chgflw_q;
  assign inject_seq_cnt        = seq_q;

endmodule

// File: tb/tb_cr_iu_hs_split_inject.sv
// tb_cr_iu_hs_split_inject: directed scenarios for the split injector.
// DUT built with DEPTH=2, CNT_W=2 so saturation is reachable.
module tb_cr_iu_hs_split_inject;

  logic        clk;
  logic        rst;
  logic        vld;
  logic [31:0] op;
  logic        rmask;
  logic        rstb;
  logic        chg;
  logic        acc;
  logic        flush;
  logic        stall;
  logic        int_en;
  logic        o_vld;
  logic [31:0] o_op;
  logic        o_rm;
  logic        o_gc;
  logic        o_chg;
  logic [1:0]  o_cnt;

  int n_chk;
  int n_fail;

  cr_iu_hs_split_inject #(
    .DEPTH (2),
    .CNT_W (2)
  ) dut (
    .forever_cpuclk               (clk),
    .cpurst                       (rst),
    .hs_split_iu_ctrl_inst_vld    (vld),
    .hs_split_iu_dp_inst_op       (op),
    .hs_split_iu_hs_retire_mask   (rmask),
    .hs_split_iu_nsinst_gpr_rst_b (rstb),
    .hs_split_iu_unstack_chgflw   (chg),
    .ex_inject_accept             (acc),
    .ex_inject_flush              (flush),
    .iu_hs_split_ex_stall         (stall),
    .iu_ifu_spcu_int_en           (int_en),
    .inject_ex_inst_vld           (o_vld),
    .inject_ex_inst_op            (o_op),
    .inject_ex_retire_mask        (o_rm),
    .inject_ex_gpr_clr            (o_gc),
    .inject_pcgen_chgflw          (o_chg),
    .inject_seq_cnt               (o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    vld   = 1'b0;
    op    = '0;
    rmask = 1'b0;
    rstb  = 1'b1;
    chg   = 1'b0;
    acc   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_chk++;
    if ({stall, int_en, o_chg} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 010",
               {stall, int_en, o_chg});
    end
    n_chk++;
    if ({o_vld, o_op, o_rm, o_gc} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_head: got %h want 0",
               {o_vld, o_op, o_rm, o_gc});
    end
    n_chk++;
    if (o_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", o_cnt);
    end
  endtask

  task automatic test_single_op();
    quiet();
    vld = 1'b1;
    op  = 32'h0000_0013;
    acc = 1'b1;
    tick();
    vld = 1'b0;
    op  = '0;
    n_chk++;
    if ({o_vld, o_op, int_en} !== {1'b1, 32'h13, 1'b0}) begin
      n_fail++;
      $display("FAIL single_head: vld=%b op=%h int_en=%b want 1 13 0",
               o_vld, o_op, int_en);
    end
    tick();
    n_chk++;
    if ({o_vld, int_en, o_cnt} !== {1'b0, 1'b0, 2'd1}) begin
      n_fail++;
      $display("FAIL single_pop: vld=%b int_en=%b cnt=%0d want 0 0 1",
               o_vld, int_en, o_cnt);
    end
    tick();
    n_chk++;
    if ({int_en, o_cnt} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL single_idle: int_en=%b cnt=%0d want 1 0",
               int_en, o_cnt);
    end
    acc = 1'b0;
  endtask

  task automatic test_backpressure();
    quiet();
    vld = 1'b1;
    op  = 32'hA;
    tick();
    n_chk++;
    if ({stall, o_op} !== {1'b0, 32'hA}) begin
      n_fail++;
      $display("FAIL bp_first: stall=%b op=%h want 0 a", stall, o_op);
    end
    op = 32'hB;
    tick();
    n_chk++;
    if ({stall, o_op} !== {1'b1, 32'hA}) begin
      n_fail++;
      $display("FAIL bp_full: stall=%b op=%h want 1 a", stall, o_op);
    end
    op = 32'hC;
    tick();
    n_chk++;
    if ({stall, o_op} !== {1'b1, 32'hA}) begin
      n_fail++;
      $display("FAIL bp_hold: stall=%b op=%h want 1 a", stall, o_op);
    end
    acc = 1'b1;
    tick();
    n_chk++;
    if ({stall, o_op} !== {1'b0, 32'hB}) begin
      n_fail++;
      $display("FAIL bp_pop: stall=%b op=%h want 0 b", stall, o_op);
    end
    acc = 1'b0;
    tick();
    vld = 1'b0;
    n_chk++;
    if ({stall, o_op} !== {1'b1, 32'hB}) begin
      n_fail++;
      $display("FAIL bp_push_c: stall=%b op=%h want 1 b", stall, o_op);
    end
    acc = 1'b1;
    tick();
    n_chk++;
    if ({o_vld, o_op} !== {1'b1, 32'hC}) begin
      n_fail++;
      $display("FAIL bp_order: vld=%b op=%h want 1 c", o_vld, o_op);
    end
    tick();
    acc = 1'b0;
    n_chk++;
    if ({o_vld, o_cnt} !== {1'b0, 2'd3}) begin
      n_fail++;
      $display("FAIL bp_drain: vld=%b cnt=%0d want 0 3", o_vld, o_cnt);
    end
    tick();
    n_chk++;
    if ({int_en, o_cnt} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL bp_idle: int_en=%b cnt=%0d want 1 0",
               int_en, o_cnt);
    end
  endtask

  task automatic test_unstack();
    quiet();
    acc = 1'b1;
    vld = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      op = 32'h100 + 32'(i);
      tick();
    end
    n_chk++;
    if ({stall, o_op} !== {1'b0, 32'h103}) begin
      n_fail++;
      $display("FAIL us_pre: stall=%b op=%h want 0 103", stall, o_op);
    end
    op  = 32'h104;
    chg = 1'b1;
    tick();
    vld = 1'b0;
    chg = 1'b0;
    n_chk++;
    if ({stall, o_op, o_chg} !== {1'b1, 32'h104, 1'b0}) begin
      n_fail++;
      $display("FAIL us_last: stall=%b op=%h chg=%b want 1 104 0",
               stall, o_op, o_chg);
    end
    tick();
    n_chk++;
    if ({o_chg, o_vld, stall, int_en} !== 4'b1010) begin
      n_fail++;
      $display("FAIL us_pulse: chg/vld/stall/int_en=%b want 1010",
               {o_chg, o_vld, stall, int_en});
    end
    n_chk++;
    if (o_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL us_cnt: got %0d want 3", o_cnt);
    end
    tick();
    acc = 1'b0;
    n_chk++;
    if ({o_chg, stall, int_en, o_cnt} !== {3'b001, 2'd0}) begin
      n_fail++;
      $display("FAIL us_idle: chg/stall/int_en=%b cnt=%0d want 001 0",
               {o_chg, stall, int_en}, o_cnt);
    end
  endtask

  task automatic test_mask_sat();
    logic [1:0] exp_cnt [7];
    exp_cnt = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    quiet();
    acc   = 1'b1;
    vld   = 1'b1;
    op    = 32'h200;
    rmask = 1'b1;
    rstb  = 1'b0;
    tick();
    rmask = 1'b0;
    rstb  = 1'b1;
    n_chk++;
    if ({o_rm, o_gc, o_cnt} !== {2'b11, 2'd0}) begin
      n_fail++;
      $display("FAIL ms_head: rm=%b gc=%b cnt=%0d want 1 1 0",
               o_rm, o_gc, o_cnt);
    end
    for (int i = 1; i <= 6; i++) begin
      op  = 32'h200 + 32'(i);
      vld = (i <= 5);
      tick();
      n_chk++;
      if (o_cnt !== exp_cnt[i]) begin
        n_fail++;
        $display("FAIL ms_cnt[%0d]: got %0d want %0d",
                 i, o_cnt, exp_cnt[i]);
      end
    end
    vld = 1'b0;
    acc = 1'b0;
    tick();
    n_chk++;
    if ({o_vld, int_en, o_cnt} !== {2'b01, 2'd0}) begin
      n_fail++;
      $display("FAIL ms_idle: vld=%b int_en=%b cnt=%0d want 0 1 0",
               o_vld, int_en, o_cnt);
    end
  endtask

  task automatic test_flush_drain();
    quiet();
    vld = 1'b1;
    op  = 32'h300;
    tick();
    op  = 32'h301;
    chg = 1'b1;
    tick();
    vld = 1'b0;
    chg = 1'b0;
    n_chk++;
    if ({stall, o_vld, o_op} !== {2'b11, 32'h300}) begin
      n_fail++;
      $display("FAIL fl_pre: stall=%b vld=%b op=%h want 1 1 300",
               stall, o_vld, o_op);
    end
    flush = 1'b1;
    acc   = 1'b1;
    vld   = 1'b1;
    op    = 32'h3FF;
    tick();
    flush = 1'b0;
    acc   = 1'b0;
    vld   = 1'b0;
    n_chk++;
    if ({o_vld, stall, o_chg, int_en, o_cnt} !== {4'b0001, 2'd0}) begin
      n_fail++;
      $display("FAIL fl_after: vld/stall/chg/int_en=%b cnt=%0d want 0001 0",
               {o_vld, stall, o_chg, int_en}, o_cnt);
    end
    tick();
    n_chk++;
    if ({o_vld, o_chg} !== 2'b00) begin
      n_fail++;
      $display("FAIL fl_nopulse: vld=%b chg=%b want 0 0", o_vld, o_chg);
    end
  endtask

  task automatic test_reset_full();
    quiet();
    vld = 1'b1;
    op  = 32'h400;
    tick();
    op  = 32'h401;
    tick();
    n_chk++;
    if ({stall, o_vld} !== 2'b11) begin
      n_fail++;
      $display("FAIL rf_full: stall=%b vld=%b want 1 1", stall, o_vld);
    end
    rst = 1'b1;
    op  = 32'h4FF;
    tick();
    rst = 1'b0;
    vld = 1'b0;
    n_chk++;
    if ({stall, int_en, o_vld, o_op, o_rm, o_gc, o_chg, o_cnt}
        !== {3'b010, 32'h0, 3'b000, 2'd0}) begin
      n_fail++;
      $display("FAIL rf_reset: stall=%b int_en=%b vld=%b op=%h cnt=%0d",
               stall, int_en, o_vld, o_op, o_cnt);
    end
    tick();
    n_chk++;
    if ({o_vld, stall, int_en} !== 3'b001) begin
      n_fail++;
      $display("FAIL rf_dropped: vld=%b stall=%b int_en=%b want 0 0 1",
               o_vld, stall, int_en);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    quiet();
    test_reset();
    test_single_op();
    test_backpressure();
    test_unstack();
    test_mask_sat();
    test_flush_drain();
    test_reset_full();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
